matrix_multiplier_seq: RTL and testbench
========================================

# matrix_multiplier_seq

Sequential, parametrised successor to the combinational 8-bit matrix multiplier. It computes C = A×B for an M×K by K×N unsigned matrix pair using a single multiply-accumulate unit, with a start/done handshake. It adds configurable element width, a saturate-or-wrap output mode and an overflow flag. It sits in the EE210 arithmetic datapath, where wide combinational multiplier arrays are too large.

## Interface
- M, 3, rows of A and C
- K, 2, columns of A / rows of B (inner dimension, ≥1)
- N, 6, columns of B and C
- W, 8, operand element width (bits)
- OW, 8, result element width (bits)
- SAT, 0, 1 = clamp result elements to 2^OW−1; 0 = keep low OW bits (wrap)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a_in  input  M*K*W  matrix A, packed row-major, element (0,0) in MSBs: element (i,k) at bits [(M*K−1−(i*K+k))*W +: W]
- b_in  input  K*N*W  matrix B, same packing: element (k,j) at bits [(K*N−1−(k*N+j))*W +: W]
- c_out  output  M*N*OW  result C, same packing: element (i,j) at bits [(M*N−1−(i*N+j))*OW +: OW]
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; c_out and ovf are valid from this cycle
- ovf  output  1  at least one element of the last result exceeded 2^OW−1

## Operation
- States: IDLE, CALC, DONE.
- IDLE: when start=1, latch a_in and b_in into internal operand registers, clear the accumulator and the i/j/k counters, clear the internal overflow accumulator, then go to CALC. Changes on a_in/b_in after that edge have no effect on the run.
- CALC: one product per cycle. acc ← acc + A[i][k]·B[k][j].
  - The accumulator is 2W+clog2(K) bits wide, enough that it never wraps.
  - Counter order: k innermost, then j, then i.
  - When k=K−1, the final sum of element (i,j) is reduced to OW bits and written to an internal result buffer. Reduction is clamp if SAT=1, truncate if SAT=0.
  - On that same write, the overflow accumulator is ORed with (sum > 2^OW−1), and the accumulator restarts at 0.
  - After element (M−1,N−1) is written, go to DONE.
- DONE: copy the result buffer to c_out and the overflow accumulator to ovf on entry. Assert done for exactly one cycle, then go to IDLE unconditionally.
- c_out and ovf hold their previous values throughout CALC. They change only on the edge that enters DONE.
- start is ignored in CALC and DONE. It is not queued.
- All arithmetic is unsigned.

## Timing
- Reset values: state=IDLE, c_out=0, busy=0, done=0, ovf=0; counters and accumulator are 0.
- Reset takes effect immediately, including mid-CALC. The run is abandoned and there is no done pulse.
- start=1 sampled at edge E0 puts the block in CALC during cycles E0+1 … E0+M·N·K.
- done=1 and new c_out/ovf appear at edge E0+M·N·K+1. With the defaults that is E0+37.
- busy rises at E0+1 and falls at E0+M·N·K+2, together with done.
- The earliest next start is sampled at edge E0+M·N·K+2 (first IDLE cycle). Back-to-back throughput is one result per M·N·K+2 cycles.
- K=1: each CALC cycle writes one element. There is no accumulation across cycles.

## Test plan
- Defaults, SAT=0: a_in={1,0,1,1,0,1}, b_in={1,0,1,0,1,0, 1,0,1,1,0,1}, start pulse. Required response:
  - c_out rows [1,0,1,0,1,0], [2,0,2,1,1,1], [1,0,1,1,0,1]
  - ovf=0
  - done exactly 37 cycles after the start edge
  - busy high 37 cycles
- Overflow, all elements 255:
  - SAT=1: every c_out element =255, ovf=1
  - SAT=0: every element =2 (130050 mod 256), ovf=1
- Start while busy: pulse start again at E0+5 with different operands. Result must equal the first operands' product, there must be only one done pulse, and the second start must not be captured.
- Operand isolation: change a_in and b_in at E0+1 to all 255. The result must still be the original product, with ovf=0.
- Reset mid-run: assert rst at E0+10. Outputs must return to 0 immediately with no done. After release, a new start must produce the correct result with done 37 cycles later.
- Generalisation: instantiate M=2, K=3, N=2, W=4, OW=10 with all operands 15. Every element must be 675, ovf=0, and done must come 13 cycles after start.

Source files
------------

// File: rtl/matrix_multiplier_seq.sv
// Sequential M x K by K x N unsigned matrix multiplier.
// One multiply-accumulate per cycle, start/done handshake.
module matrix_multiplier_seq #(
  parameter int M   = 3,
  parameter int K   = 2,
  parameter int N   = 6,
  parameter int W   = 8,
  parameter int OW  = 8,
  parameter int SAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [M*K*W-1:0]    a_in,
  input  logic [K*N*W-1:0]    b_in,
  output logic [M*N*OW-1:0]   c_out,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int AW = 2*W + $clog2(K);
  localparam int XW = (AW > OW) ? AW : OW;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(M-1);
  localparam logic [JW-1:0] J_LAST = JW'(N-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
  localparam logic [XW-1:0] MAXV = XW'({OW{1'b1}});

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [M*K*W-1:0]  a_q;
  logic [K*N*W-1:0]  b_q;
  logic [W-1:0]      a_e [M][K];
  logic [W-1:0]      b_e [K][N];
  logic [OW-1:0]     res_q [M][N];
  logic [M*N*OW-1:0] c_nx;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;

  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [2*W-1:0] prod;
  logic [XW-1:0]  sum_x;
  logic [OW-1:0]  red;
  logic           elem_ovf;
  logic           ovf_acc;
  logic           k_last;
  logic           last;

  for (genvar gi = 0; gi < M; gi++) begin : g_a_r
    for (genvar gk = 0; gk < K; gk++) begin : g_a_c
      assign a_e[gi][gk] = a_q[(M*K-1-(gi*K+gk))*W +: W];
    end
  end

  for (genvar gk = 0; gk < K; gk++) begin : g_b_r
    for (genvar gj = 0; gj < N; gj++) begin : g_b_c
      assign b_e[gk][gj] = b_q[(K*N-1-(gk*N+gj))*W +: W];
    end
  end

  // The final element is only ever packed on the edge it is produced,
  // so it is taken straight from the reducer instead of the buffer.
  for (genvar gi = 0; gi < M; gi++) begin : g_c_r
    for (genvar gj = 0; gj < N; gj++) begin : g_c_c
      if (gi == M-1 && gj == N-1) begin : g_tail
        assign c_nx[(M*N-1-(gi*N+gj))*OW +: OW] = red;
      end else begin : g_body
        assign c_nx[(M*N-1-(gi*N+gj))*OW +: OW] = res_q[gi][gj];
      end
    end
  end

  assign prod     = {{W{1'b0}}, a_e[i][k]} * {{W{1'b0}}, b_e[k][j]};
  assign sum      = acc + AW'(prod);
  assign sum_x    = XW'(sum);
  assign elem_ovf = sum_x > MAXV;
  assign red      = (SAT != 0 && elem_ovf) ? {OW{1'b1}} : sum_x[OW-1:0];
  assign k_last   = k == K_LAST;
  assign last     = (state == CALC) && k_last && (j == J_LAST) && (i == I_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE:    ;
      CALC:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Operand capture, MAC loop, result buffer and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      ovf_acc <= 1'b0;
      c_out   <= '0;
      ovf     <= 1'b0;
      for (int x = 0; x < M; x++)
        for (int y = 0; y < N; y++)
          res_q[x][y] <= '0;
    end else begin
      if (state == IDLE && start) begin
        a_q     <= a_in;
        b_q     <= b_in;
        acc     <= '0;
        i       <= '0;
        j       <= '0;
        k       <= '0;
        ovf_acc <= 1'b0;
      end
      if (state == CALC) begin
        if (k_last) begin
          acc         <= '0;
          k           <= '0;
          ovf_acc     <= ovf_acc | elem_ovf;
          res_q[i][j] <= red;
          if (j == J_LAST) begin
            j <= '0;
            i <= (i == I_LAST) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          acc <= sum;
          k   <= k + 1'b1;
        end
        if (last) begin
          c_out <= c_nx;
          ovf   <= ovf_acc | elem_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_multiplier_seq.sv
// Bench for matrix_multiplier_seq: vector table, random runs
// against an arithmetic model, and multi-cycle corner sequences.
module tb_matrix_multiplier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start0;
  logic [47:0]  a0;
  logic [95:0]  b0;
  logic [143:0] c0, c1;
  logic         busy0, done0, ovf0;
  logic         busy1, done1, ovf1;
  logic         start2;
  logic [23:0]  a2, b2;
  logic [39:0]  c2;
  logic         busy2, done2, ovf2;

  matrix_multiplier_seq #(.SAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a_in(a0), .b_in(b0),
    .c_out(c0), .busy(busy0), .done(done0), .ovf(ovf0)
  );

  matrix_multiplier_seq #(.SAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start0), .a_in(a0), .b_in(b0),
    .c_out(c1), .busy(busy1), .done(done1), .ovf(ovf1)
  );

  matrix_multiplier_seq #(
    .M(2), .K(3), .N(2), .W(4), .OW(10), .SAT(0)
  ) u2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2),
    .c_out(c2), .busy(busy2), .done(done2), .ovf(ovf2)
  );

  typedef struct {
    logic [47:0]  a;
    logic [95:0]  b;
    logic [143:0] c0;
    logic         o0;
    logic [143:0] c1;
    logic         o1;
  } vec_t;

  vec_t tbl [6];

  int total = 0;
  int bad   = 0;
  logic [143:0] prev0, prev1;
  logic         pov0, pov1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // C = A*B from the element definitions, plain integer arithmetic.
  task automatic model(input int mm, input int kk, input int nn,
                       input int w, input int ow, input int sat,
                       input logic [255:0] a, input logic [255:0] b,
                       output logic [255:0] c, output logic ov);
    longint wm, om, s, ae, be, v;
    wm = (64'd1 << w) - 1;
    om = (64'd1 << ow) - 1;
    c  = '0;
    ov = 1'b0;
    for (int r = 0; r < mm; r++) begin
      for (int q = 0; q < nn; q++) begin
        s = 0;
        for (int p = 0; p < kk; p++) begin
          ae = longint'((a >> ((mm*kk-1-(r*kk+p))*w)) & 256'(wm));
          be = longint'((b >> ((kk*nn-1-(p*nn+q))*w)) & 256'(wm));
          s += ae * be;
        end
        if (s > om) ov = 1'b1;
        v = (sat != 0 && s > om) ? om : (s & om);
        c |= 256'(v) << ((mm*nn-1-(r*nn+q))*ow);
      end
    end
  endtask

  task automatic rnd_ops(input int maxv, output logic [47:0] a,
                         output logic [95:0] b);
    a = '0;
    b = '0;
    for (int x = 0; x < 6; x++)
      a = (a << 8) | 48'($urandom_range(0, maxv));
    for (int x = 0; x < 12; x++)
      b = (b << 8) | 96'($urandom_range(0, maxv));
  endtask

  // mode 0: plain run; 1: second start at E0+5; 2: operands
  // disturbed right after the capture edge.
  task automatic run_d(input string tag, input logic [47:0] a,
                       input logic [95:0] b, input int mode,
                       input logic [143:0] e0, input logic o0,
                       input logic [143:0] e1, input logic o1);
    int   n, dones, bcnt, xb;
    logic got;
    a0 = a;
    b0 = b;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 1;
    dones = 0;
    bcnt = 0;
    got = 1'b0;
    while (!got && n <= 200) begin
      if (mode == 2 && n == 1) begin
        a0 = '1;
        b0 = '1;
      end
      if (mode == 1 && n == 5) begin
        start0 = 1'b1;
        a0 = {6{8'h07}};
        b0 = {12{8'h03}};
      end
      if (mode == 1 && n == 6) start0 = 1'b0;
      if (n == 5) begin
        chk({tag, "_hold_c"}, 256'(c0), 256'(prev0));
        chk({tag, "_hold_ovf"}, 256'(ovf0), 256'(pov0));
        chk({tag, "_hold_c_sat"}, 256'(c1), 256'(prev1));
      end
      if (busy0) bcnt++;
      if (done0) begin
        dones++;
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no done after %0d cycles", tag, n);
    end else begin
      chk({tag, "_latency"}, 256'(n), 256'(37));
      chk({tag, "_busy_cycles"}, 256'(bcnt), 256'(37));
      chk({tag, "_c"}, 256'(c0), 256'(e0));
      chk({tag, "_ovf"}, 256'(ovf0), 256'(o0));
      chk({tag, "_done_sat"}, 256'(done1), 256'(1));
      chk({tag, "_c_sat"}, 256'(c1), 256'(e1));
      chk({tag, "_ovf_sat"}, 256'(ovf1), 256'(o1));
    end
    xb = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done0) dones++;
      if (busy0 || busy1) xb++;
    end
    chk({tag, "_done_pulses"}, 256'(dones), 256'(1));
    chk({tag, "_idle_after"}, 256'(xb), 256'(0));
    prev0 = e0;
    prev1 = e1;
    pov0  = o0;
    pov1  = o1;
  endtask

  task automatic run_g(input string tag, input logic [23:0] a,
                       input logic [23:0] b, input logic [39:0] e,
                       input logic o);
    int   n, bcnt;
    logic got;
    a2 = a;
    b2 = b;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 1;
    bcnt = 0;
    got = 1'b0;
    while (!got && n <= 100) begin
      if (busy2) bcnt++;
      if (done2) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no done after %0d cycles", tag, n);
    end else begin
      chk({tag, "_latency"}, 256'(n), 256'(13));
      chk({tag, "_busy_cycles"}, 256'(bcnt), 256'(13));
      chk({tag, "_c"}, 256'(c2), 256'(e));
      chk({tag, "_ovf"}, 256'(ovf2), 256'(o));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [47:0]  ra;
    logic [95:0]  rb;
    logic [255:0] m0, m1;
    logic         mo0, mo1;
    logic [23:0]  ga, gb;
    int           dn, bz;

    tbl[0] = '{a: {8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1},
               b: {8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0,
                   8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1},
               c0: {8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0,
                    8'd2, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1,
                    8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1},
               o0: 1'b0,
               c1: {8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0,
                    8'd2, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1,
                    8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1},
               o1: 1'b0};
    tbl[1] = '{a: {6{8'hFF}}, b: {12{8'hFF}},
               c0: {18{8'd2}}, o0: 1'b1,
               c1: {18{8'hFF}}, o1: 1'b1};
    tbl[2] = '{a: '0, b: '0, c0: '0, o0: 1'b0, c1: '0, o1: 1'b0};
    tbl[3] = '{a: {8'd200, 8'd100, 8'd0, 8'd0, 8'd1, 8'd1},
               b: {12{8'd1}},
               c0: {{6{8'd44}}, {6{8'd0}}, {6{8'd2}}}, o0: 1'b1,
               c1: {{6{8'd255}}, {6{8'd0}}, {6{8'd2}}}, o1: 1'b1};
    tbl[4] = '{a: {8'd255, 8'd0, 8'd15, 8'd0, 8'd0, 8'd0},
               b: {{6{8'd1}}, {6{8'd17}}},
               c0: {{6{8'd255}}, {6{8'd15}}, {6{8'd0}}}, o0: 1'b0,
               c1: {{6{8'd255}}, {6{8'd15}}, {6{8'd0}}}, o1: 1'b0};
    tbl[5] = '{a: {8'd128, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0},
               b: {12{8'd1}},
               c0: '0, o0: 1'b1,
               c1: {{6{8'hFF}}, {12{8'd0}}}, o1: 1'b1};

    rst = 1'b1;
    start0 = 1'b0;
    a0 = '0;
    b0 = '0;
    start2 = 1'b0;
    a2 = '0;
    b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c", 256'(c0), 256'(0));
    chk("rst_busy", 256'(busy0), 256'(0));
    chk("rst_done", 256'(done0), 256'(0));
    chk("rst_ovf", 256'(ovf0), 256'(0));
    chk("rst_c_gen", 256'(c2), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    prev0 = '0;
    prev1 = '0;
    pov0  = 1'b0;
    pov1  = 1'b0;

    for (int v = 0; v < 6; v++)
      run_d($sformatf("vec%0d", v), tbl[v].a, tbl[v].b, 0,
            tbl[v].c0, tbl[v].o0, tbl[v].c1, tbl[v].o1);

    for (int r = 0; r < 6; r++) begin
      rnd_ops((r % 2 == 0) ? 11 : 255, ra, rb);
      model(3, 2, 6, 8, 8, 0, 256'(ra), 256'(rb), m0, mo0);
      model(3, 2, 6, 8, 8, 1, 256'(ra), 256'(rb), m1, mo1);
      run_d($sformatf("rnd%0d", r), ra, rb, 0,
            m0[143:0], mo0, m1[143:0], mo1);
    end

    run_d("busy_start", tbl[0].a, tbl[0].b, 1,
          tbl[0].c0, tbl[0].o0, tbl[0].c1, tbl[0].o1);
    run_d("isolation", tbl[4].a, tbl[4].b, 2,
          tbl[4].c0, tbl[4].o0, tbl[4].c1, tbl[4].o1);

    a0 = tbl[1].a;
    b0 = tbl[1].b;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_c", 256'(c0), 256'(0));
    chk("midrst_c_sat", 256'(c1), 256'(0));
    chk("midrst_ovf", 256'(ovf0), 256'(0));
    chk("midrst_busy", 256'(busy0), 256'(0));
    chk("midrst_done", 256'(done0), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    bz = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done0 || done1) dn++;
      if (busy0 || busy1) bz++;
    end
    chk("midrst_no_done", 256'(dn), 256'(0));
    chk("midrst_no_busy", 256'(bz), 256'(0));
    prev0 = '0;
    prev1 = '0;
    pov0  = 1'b0;
    pov1  = 1'b0;
    run_d("after_rst", tbl[0].a, tbl[0].b, 0,
          tbl[0].c0, tbl[0].o0, tbl[0].c1, tbl[0].o1);

    run_g("gen_15", {6{4'hF}}, {6{4'hF}}, {4{10'd675}}, 1'b0);
    for (int r = 0; r < 3; r++) begin
      ga = 24'($urandom);
      gb = 24'($urandom);
      model(2, 3, 2, 4, 10, 0, 256'(ga), 256'(gb), m0, mo0);
      run_g($sformatf("gen_rnd%0d", r), ga, gb, m0[39:0], mo0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
